nebula_config_arbiter: RTL and testbench
========================================

// Module: nebula_config_arbiter
// PURPOSE
//  Shares the single nebula_top configuration port among NUM_REQ requesters (host, debug, per-cluster agents).
//  Round-robin arbiter with one outstanding transaction; routes each response back to its owner.
//  Applies a response timeout so a hung target cannot lock the config bus.
// PARAMETERS
//  NUM_REQ         4    number of requesters (>=2)
//  ADDR_WIDTH      16   config address width (matches CONFIG_ADDR_WIDTH)
//  DATA_WIDTH      32   config data width (matches CONFIG_DATA_WIDTH)
//  TIMEOUT_CYCLES  256  cycles from ISSUE entry until the transaction is forced to complete (>=4)
// PORTS
//  clk              in   1                     system clock
//  rst              in   1                     synchronous, active-high reset
//  req_valid        in   NUM_REQ               per-requester request valid
//  req_ready        out  NUM_REQ               per-requester accept (one-hot or zero)
//  req_write        in   NUM_REQ               1=write, 0=read
//  req_addr         in   NUM_REQ x ADDR_WIDTH  request address
//  req_data         in   NUM_REQ x DATA_WIDTH  write data
//  resp_valid       out  NUM_REQ               response valid to owner (one-hot or zero)
//  resp_ready       in   NUM_REQ               requester response ready
//  resp_data        out  DATA_WIDTH            response data (shared; qualified by resp_valid)
//  resp_error       out  1                     response error (target error or timeout)
//  cfg_req_valid    out  1                     to nebula_top config_req_valid
//  cfg_req_ready    in   1                     from config_req_ready
//  cfg_req_write    out  1                     to config_req_write
//  cfg_req_addr     out  ADDR_WIDTH            to config_req_addr
//  cfg_req_data     out  DATA_WIDTH            to config_req_data
//  cfg_resp_valid   in   1                     from config_resp_valid
//  cfg_resp_ready   out  1                     to config_resp_ready
//  cfg_resp_data    in   DATA_WIDTH            from config_resp_data
//  cfg_resp_error   in   1                     from config_resp_error
//  busy             out  1                     state != IDLE
//  grant_id         out  $clog2(NUM_REQ)       current/last owner index
//  timeout_count    out  16                    timeouts since reset, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, round-robin pointer so that requester 0 has top priority.
//   Reset in any state abandons the in-flight transaction; no response is produced for it.
//  FSM IDLE -> ISSUE -> WAIT_RESP -> RESP -> IDLE.
//  IDLE: winner = first req_valid at or after (last_grant+1) mod NUM_REQ; req_ready[winner]=1 combinationally
//   that cycle; write/addr/data latched; grant_id=winner; next state ISSUE. No req_valid: stay.
//  ISSUE: cfg_req_valid=1 with latched fields, held stable; on cfg_req_ready -> WAIT_RESP.
//  WAIT_RESP: cfg_resp_ready=1; on cfg_resp_valid latch data/error -> RESP.
//  RESP: resp_valid[owner]=1, resp_data/resp_error registered, held until resp_ready[owner]; then last_grant=owner,
//   state IDLE. Other requesters' resp_ready ignored.
//  Timer: cleared on ISSUE entry, increments in ISSUE/WAIT_RESP; at TIMEOUT_CYCLES-1 with no handshake
//   -> RESP with resp_data=0, resp_error=1, timeout_count+1 (saturating); cfg_req_valid drops.
//   Handshake in the same cycle as expiry wins (no timeout).
//  cfg_resp_ready also 1 in IDLE: stray/late responses are consumed and dropped.
//  Latency: accept T, cfg_req_valid T+1; zero-wait target -> resp_valid T+3; next accept earliest T+4.
//  req_valid may drop without handshake; arbiter re-evaluates every IDLE cycle.
// TESTING
//  Req2 write addr 16'h0040 data 32'hCAFE0001, target zero-wait -> cfg_req at T+1, resp_valid[2] at T+3, error 0.
//  All four req_valid held high -> grant order 0,1,2,3,0; each requester granted once per 4 transactions.
//  req0 always valid, req1 valid -> grants alternate 0,1,0,1.
//  TIMEOUT_CYCLES=16, cfg_req_ready=0 -> after 16 cycles resp_valid, resp_error=1, resp_data=0, timeout_count=1.
//  resp_ready[owner]=0 for 10 cycles -> resp_valid/resp_data stable 10 cycles, no new grant issued.
//  rst asserted in WAIT_RESP -> next cycle all outputs 0, busy=0; subsequent req1 read completes normally.

Source files
------------

// File: rtl/nebula_config_arbiter.sv
// Round-robin owner of the single config port: one transaction in flight, response steered back to its owner.
// Accept T, cfg_req T+1, resp T+3 on a zero-wait target; requester and target stall via valid/ready, hung target times out.
module nebula_config_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0]                   req_write,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]                   resp_valid,
   input  logic [NUM_REQ-1:0]                   resp_ready,
   output logic [DATA_WIDTH-1:0]                resp_data,
   output logic                                 resp_error,
   output logic                                 cfg_req_valid,
   input  logic                                 cfg_req_ready,
   output logic                                 cfg_req_write,
   output logic [ADDR_WIDTH-1:0]                cfg_req_addr,
   output logic [DATA_WIDTH-1:0]                cfg_req_data,
   input  logic                                 cfg_resp_valid,
   output logic                                 cfg_resp_ready,
   input  logic [DATA_WIDTH-1:0]                cfg_resp_data,
   input  logic                                 cfg_resp_error,
   output logic                                 busy,
   output logic [$clog2(NUM_REQ)-1:0]           grant_id,
   output logic [15:0]                          timeout_count
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESP} state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } hdr_t;

   state_t            state;
   hdr_t              hdr;
   logic [GW-1:0]     last_grant;
   logic [TW-1:0]     timer;
   logic              win_vld;
   logic [GW-1:0]     win_idx;
   logic [GW-1:0]     cand;
   logic [NUM_REQ-1:0] owner_oh;

   assign cfg_req_write = hdr.write;
   assign cfg_req_addr  = hdr.addr;
   assign cfg_req_data  = hdr.data;
   assign owner_oh      = NUM_REQ'(1) << grant_id;

   // Search starts just after the last owner, so the last owner ranks lowest.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = GW'((int'(last_grant) + i) % NUM_REQ);
         if (!win_vld && req_valid[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && win_vld && !rst)
         req_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         hdr            <= '0;
         last_grant     <= GW'(NUM_REQ - 1);
         grant_id       <= '0;
         timer          <= '0;
         cfg_req_valid  <= 1'b0;
         cfg_resp_ready <= 1'b0;
         resp_valid     <= '0;
         resp_data      <= '0;
         resp_error     <= 1'b0;
         busy           <= 1'b0;
         timeout_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               cfg_resp_ready <= 1'b1;
               if (win_vld) begin
                  hdr            <= '{write: req_write[win_idx], addr: req_addr[win_idx],
                                      data: req_data[win_idx]};
                  grant_id       <= win_idx;
                  timer          <= '0;
                  cfg_req_valid  <= 1'b1;
                  cfg_resp_ready <= 1'b0;
                  busy           <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE, WAIT_RESP: begin
               // Timer saturates so a request accepted on the last cycle still gets one response cycle.
               if (timer != TMAX)
                  timer <= timer + 1'b1;
               if (state == ISSUE && cfg_req_ready) begin
                  cfg_req_valid  <= 1'b0;
                  cfg_resp_ready <= 1'b1;
                  state          <= WAIT_RESP;
               end else if (state == WAIT_RESP && cfg_resp_valid) begin
                  cfg_resp_ready <= 1'b0;
                  resp_data      <= cfg_resp_data;
                  resp_error     <= cfg_resp_error;
                  resp_valid     <= owner_oh;
                  state          <= RESP;
               end else if (timer == TMAX) begin
                  cfg_req_valid  <= 1'b0;
                  cfg_resp_ready <= 1'b0;
                  resp_data      <= '0;
                  resp_error     <= 1'b1;
                  resp_valid     <= owner_oh;
                  if (timeout_count != 16'hFFFF)
                     timeout_count <= timeout_count + 16'd1;
                  state          <= RESP;
               end
            end
            RESP: begin
               if (resp_ready[grant_id]) begin
                  resp_valid     <= '0;
                  last_grant     <= grant_id;
                  busy           <= 1'b0;
                  cfg_resp_ready <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nebula_config_arbiter.sv
// Directed bench for nebula_config_arbiter: table of zero-wait transactions plus timeout,
// response-stall and mid-flight reset sequences.
module tb_nebula_config_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        req_valid, req_ready, req_write;
   logic [3:0][15:0]  req_addr;
   logic [3:0][31:0]  req_data;
   logic [3:0]        resp_valid, resp_ready;
   logic [31:0]       resp_data;
   logic              resp_error;
   logic              cfg_req_valid, cfg_req_ready, cfg_req_write;
   logic [15:0]       cfg_req_addr;
   logic [31:0]       cfg_req_data;
   logic              cfg_resp_valid, cfg_resp_ready, cfg_resp_error;
   logic [31:0]       cfg_resp_data;
   logic              busy;
   logic [1:0]        grant_id;
   logic [15:0]       timeout_count;

   int vectors = 0;
   int miscompares = 0;

   nebula_config_arbiter #(
      .NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_error(resp_error),
      .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready),
      .cfg_req_write(cfg_req_write), .cfg_req_addr(cfg_req_addr), .cfg_req_data(cfg_req_data),
      .cfg_resp_valid(cfg_resp_valid), .cfg_resp_ready(cfg_resp_ready),
      .cfg_resp_data(cfg_resp_data), .cfg_resp_error(cfg_resp_error),
      .busy(busy), .grant_id(grant_id), .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rv;
      logic [31:0] td;
      logic        te;
      logic [3:0]  exp_oh;
      int          gid;
   } vec_t;

   vec_t vt[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_resp_data"}, resp_data, 0);
      check({tag, "_resp_error"}, resp_error, 0);
      check({tag, "_cfg_req_valid"}, cfg_req_valid, 0);
      check({tag, "_cfg_req_fields"}, {cfg_req_write, cfg_req_addr, cfg_req_data}, 0);
      check({tag, "_cfg_resp_ready"}, cfg_resp_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_grant_id"}, grant_id, 0);
      check({tag, "_timeout_count"}, timeout_count, 0);
   endtask

   // One zero-wait transaction starting in an IDLE cycle; ends in the following IDLE cycle.
   task automatic do_txn(input string tag, input logic [3:0] rv, input logic [31:0] td,
                         input logic te, input logic [3:0] exp_oh, input int gid,
                         input logic ew, input logic [15:0] ea, input logic [31:0] ed);
      cfg_req_ready  = 1'b1;
      cfg_resp_valid = 1'b1;
      cfg_resp_data  = td;
      cfg_resp_error = te;
      resp_ready     = 4'hF;
      req_valid      = rv;
      #1;
      check({tag, "_req_ready"}, req_ready, exp_oh);
      check({tag, "_busy_idle"}, busy, 0);
      cyc();
      req_valid = 4'h0;
      #1;
      check({tag, "_cfg_req_valid"}, cfg_req_valid, 1);
      check({tag, "_grant_id"}, grant_id, gid);
      check({tag, "_cfg_req_fields"}, {cfg_req_write, cfg_req_addr, cfg_req_data}, {ew, ea, ed});
      check({tag, "_busy"}, busy, 1);
      cyc();
      check({tag, "_wait_cfg_resp_ready"}, cfg_resp_ready, 1);
      check({tag, "_wait_no_resp"}, resp_valid, 0);
      cyc();
      check({tag, "_resp_valid"}, resp_valid, exp_oh);
      check({tag, "_resp_data"}, resp_data, td);
      check({tag, "_resp_error"}, resp_error, te);
      cyc();
      check({tag, "_resp_done"}, resp_valid, 0);
   endtask

   initial begin
      logic [3:0] wr_base;
      wr_base = 4'b0101;

      vt[0]  = '{4'b1000, 32'h1111_0000, 1'b0, 4'b1000, 3};
      vt[1]  = '{4'b1111, 32'h1111_0001, 1'b0, 4'b0001, 0};
      vt[2]  = '{4'b1111, 32'h1111_0002, 1'b1, 4'b0010, 1};
      vt[3]  = '{4'b1111, 32'h1111_0003, 1'b0, 4'b0100, 2};
      vt[4]  = '{4'b1111, 32'h1111_0004, 1'b0, 4'b1000, 3};
      vt[5]  = '{4'b1111, 32'h1111_0005, 1'b1, 4'b0001, 0};
      vt[6]  = '{4'b1000, 32'h2222_0006, 1'b0, 4'b1000, 3};
      vt[7]  = '{4'b0011, 32'h2222_0007, 1'b0, 4'b0001, 0};
      vt[8]  = '{4'b0011, 32'h2222_0008, 1'b0, 4'b0010, 1};
      vt[9]  = '{4'b0011, 32'h2222_0009, 1'b1, 4'b0001, 0};
      vt[10] = '{4'b0011, 32'h2222_000A, 1'b0, 4'b0010, 1};
      vt[11] = '{4'b0110, 32'h3333_000B, 1'b0, 4'b0100, 2};
      vt[12] = '{4'b1001, 32'h3333_000C, 1'b0, 4'b1000, 3};
      vt[13] = '{4'b1001, 32'h3333_000D, 1'b1, 4'b0001, 0};

      rst = 1'b1;
      req_valid = 4'hF;
      req_write = wr_base;
      for (int i = 0; i < 4; i++) begin
         req_addr[i] = 16'h0A00 + 16'(i * 16);
         req_data[i] = 32'hD000_0000 + 32'(i);
      end
      resp_ready = 4'hF;
      cfg_req_ready = 1'b0;
      cfg_resp_valid = 1'b0;
      cfg_resp_data = 32'h0;
      cfg_resp_error = 1'b0;
      cyc();
      cyc();
      check_all_zero("reset");
      req_valid = 4'h0;
      rst = 1'b0;
      cyc();

      // Requester 2 write, zero-wait target.
      req_addr[2] = 16'h0040;
      req_data[2] = 32'hCAFE0001;
      req_write[2] = 1'b1;
      do_txn("req2_write", 4'b0100, 32'h0000_ABCD, 1'b0, 4'b0100, 2, 1'b1, 16'h0040, 32'hCAFE0001);
      req_addr[2] = 16'h0A20;
      req_data[2] = 32'hD000_0002;
      req_write = wr_base;

      for (int k = 0; k < 14; k++)
         do_txn($sformatf("vec%0d", k), vt[k].rv, vt[k].td, vt[k].te, vt[k].exp_oh, vt[k].gid,
                wr_base[vt[k].gid], 16'h0A00 + 16'(vt[k].gid * 16), 32'hD000_0000 + 32'(vt[k].gid));

      // Hung target: no cfg_req_ready, timeout after 16 cycles in ISSUE.
      cfg_req_ready = 1'b0;
      cfg_resp_valid = 1'b0;
      req_valid = 4'b0010;
      #1;
      check("tmo_req_ready", req_ready, 4'b0010);
      cyc();
      req_valid = 4'h0;
      check("tmo_cfg_req_valid_first", cfg_req_valid, 1);
      repeat (15) cyc();
      check("tmo_cfg_req_valid_last", cfg_req_valid, 1);
      check("tmo_not_yet", resp_valid, 0);
      cyc();
      check("tmo_resp_valid", resp_valid, 4'b0010);
      check("tmo_resp_error", resp_error, 1);
      check("tmo_resp_data", resp_data, 0);
      check("tmo_count", timeout_count, 1);
      check("tmo_cfg_req_dropped", cfg_req_valid, 0);
      // Owner stalls for 10 cycles; other requesters' ready must be ignored.
      resp_ready = 4'b1101;
      req_valid = 4'hF;
      #1;
      for (int i = 0; i < 10; i++) begin
         check("stall_resp_valid", resp_valid, 4'b0010);
         check("stall_resp_data", {resp_error, resp_data}, {1'b1, 32'h0});
         check("stall_no_grant", {req_ready, grant_id}, {4'b0000, 2'd1});
         cyc();
      end
      resp_ready = 4'hF;
      req_valid = 4'h0;
      cyc();
      check("stall_release", {resp_valid, busy}, {4'b0000, 1'b0});

      // Handshake on the expiry cycle wins over the timeout.
      req_valid = 4'b0100;
      cyc();
      req_valid = 4'h0;
      repeat (14) cyc();
      check("exp_hs_still_issuing", cfg_req_valid, 1);
      cyc();
      cfg_req_ready = 1'b1;
      cfg_resp_valid = 1'b1;
      cfg_resp_data = 32'h5A5A_1234;
      cfg_resp_error = 1'b0;
      cyc();
      cfg_req_ready = 1'b0;
      check("exp_hs_wait", {cfg_req_valid, cfg_resp_ready, resp_valid}, {1'b0, 1'b1, 4'b0000});
      cyc();
      check("exp_hs_resp_valid", resp_valid, 4'b0100);
      check("exp_hs_resp", {resp_error, resp_data}, {1'b0, 32'h5A5A_1234});
      check("exp_hs_count", timeout_count, 1);
      cyc();

      // Reset while waiting for the response abandons the transaction.
      cfg_req_ready = 1'b1;
      cfg_resp_valid = 1'b0;
      req_valid = 4'b0001;
      cyc();
      req_valid = 4'h0;
      cyc();
      check("rstw_in_wait", {cfg_resp_ready, busy}, {1'b1, 1'b1});
      rst = 1'b1;
      req_valid = 4'hF;
      cyc();
      check_all_zero("rst_wait");
      rst = 1'b0;
      req_valid = 4'h0;
      cyc();
      check("rstw_no_resp", resp_valid, 0);
      do_txn("post_rst_req1", 4'b0010, 32'h0BAD_F00D, 1'b0, 4'b0010, 1,
             wr_base[1], 16'h0A10, 32'hD000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
